// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: Moore decode of state, with fetch strobes and the store completion gated by mem_ready_i.
// Latency: 2-5 cycles per instruction plus one per memory wait; waits hold strobes and address selects stable.
module mc_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       BranchNe_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       MemtoReg_o,
    output logic       RegDst_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] PCSrc_o,
    output logic [2:0] ALU_op_o,
    output logic       instr_done_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_BEQ   = 3'b001;
    localparam logic [2:0] ALU_BNE   = 3'b011;
    localparam logic [2:0] ALU_SLTIU = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;
    localparam logic [2:0] ALU_ORI   = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nxt;
    end

    assign state_o = state;

    always_comb begin
        state_nxt     = S_FETCH;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        BranchNe_o    = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        PCSrc_o       = 2'b00;
        ALU_op_o      = 3'b000;
        instr_done_o  = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                // PC+4 is computed every wait cycle but only latched on the ready cycle
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                ALU_op_o  = ALU_ADD;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
                state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                ALU_op_o  = ALU_ADD;
                case (instr_op_i)
                    OP_RTYPE:                            state_nxt = S_EXEC;
                    OP_LW, OP_SW:                        state_nxt = S_MEMADR;
                    OP_BEQ, OP_BNE:                      state_nxt = S_BRANCH;
                    OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI:   state_nxt = S_IEXEC;
                    OP_J:                                state_nxt = S_JUMP;
                    default: begin
                        state_nxt    = S_FETCH;
                        instr_done_o = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALU_op_o  = ALU_ADD;
                state_nxt = (instr_op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                state_nxt = mem_ready_i ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite_o   = 1'b1;
                MemtoReg_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEMWR: begin
                MemWrite_o   = 1'b1;
                IorD_o       = 1'b1;
                instr_done_o = mem_ready_i;
                state_nxt    = mem_ready_i ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALU_op_o  = ALU_RTYPE;
                state_nxt = S_RWB;
            end
            S_RWB: begin
                RegWrite_o   = 1'b1;
                RegDst_o     = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                PCWriteCond_o = 1'b1;
                PCSrc_o       = 2'b01;
                instr_done_o  = 1'b1;
                BranchNe_o    = (instr_op_i == OP_BNE);
                ALU_op_o      = (instr_op_i == OP_BNE) ? ALU_BNE : ALU_BEQ;
            end
            S_IEXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_nxt = S_IWB;
                case (instr_op_i)
                    OP_SLTIU: ALU_op_o = ALU_SLTIU;
                    OP_LUI:   ALU_op_o = ALU_LUI;
                    OP_ORI:   ALU_op_o = ALU_ORI;
                    default:  ALU_op_o = ALU_ADD;
                endcase
            end
            S_IWB: begin
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_JUMP: begin
                PCWrite_o    = 1'b1;
                PCSrc_o      = 2'b10;
                instr_done_o = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction state-path model plus a per-state output table checked every cycle,
// with literal state traces pinning the model's paths.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memtoreg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       done;
    } out_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [5:0] instr_op_i = 6'd0;
    logic       mem_ready_i = 1'b1;
    logic       PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o, MemWrite_o;
    logic       IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, instr_done_o;
    logic [1:0] ALUSrcB_o, PCSrc_o;
    logic [2:0] ALU_op_o;
    logic [3:0] state_o;

    mc_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .BranchNe_o(BranchNe_o),
        .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
        .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .PCSrc_o(PCSrc_o), .ALU_op_o(ALU_op_o),
        .instr_done_o(instr_done_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    out_t got;
    assign got = {PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                  MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSrc_o, ALU_op_o, instr_done_o};

    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;
    logic [3:0]  exp_state = 4'd0;
    logic        exp_rdy = 1'b0;
    logic [63:0] trace = 64'd0;
    int          done_cnt = 0;

    function automatic bit known_op(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0B, 6'h0F, 6'h0D, 6'h02};
    endfunction

    // What the control lines must be in a given state, straight from the state descriptions
    function automatic out_t exp_out(input logic [3:0] s, input logic [5:0] op, input logic rdy);
        out_t o = '0;
        case (s)
            4'd1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b100;
                         o.ir_write = rdy; o.pc_write = rdy; end
            4'd2:  begin o.alu_src_b = 2'b11; o.alu_op = 3'b100; o.done = !known_op(op); end
            4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b100; end
            4'd4:  begin o.mem_read = 1; o.iord = 1; end
            4'd5:  begin o.reg_write = 1; o.memtoreg = 1; o.done = 1; end
            4'd6:  begin o.mem_write = 1; o.iord = 1; o.done = rdy; end
            4'd7:  begin o.alu_src_a = 1; o.alu_op = 3'b010; end
            4'd8:  begin o.reg_write = 1; o.reg_dst = 1; o.done = 1; end
            4'd9:  begin o.alu_src_a = 1; o.pc_write_cond = 1; o.pc_src = 2'b01; o.done = 1;
                         o.branch_ne = (op == 6'h05); o.alu_op = (op == 6'h05) ? 3'b011 : 3'b001; end
            4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10;
                         case (op)
                             6'h0B:   o.alu_op = 3'b101;
                             6'h0F:   o.alu_op = 3'b110;
                             6'h0D:   o.alu_op = 3'b111;
                             default: o.alu_op = 3'b100;
                         endcase end
            4'd11: begin o.reg_write = 1; o.done = 1; end
            4'd12: begin o.pc_write = 1; o.pc_src = 2'b10; o.done = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    always @(negedge clk_i) begin
        if (chk_en) begin
            out_t e;
            e = exp_out(exp_state, instr_op_i, exp_rdy);
            checks++;
            if (got !== e || state_o !== exp_state) begin
                errors++;
                $display("FAIL cycle t=%0t op=%h: state got %0d want %0d, outputs got %h want %h",
                         $time, instr_op_i, state_o, exp_state, got, e);
            end
            trace = {trace[59:0], state_o};
            if (instr_done_o) done_cnt++;
        end
    end

    // Build one instruction's cycle-by-cycle state path from its class, then drive it
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int max_cyc,
                             input string name, input logic [63:0] exp_trace);
        int st[$];
        bit rd[$];
        int n;
        for (int i = 0; i < fw; i++) begin st.push_back(1); rd.push_back(0); end
        st.push_back(1); rd.push_back(1);
        st.push_back(2); rd.push_back(0);
        case (op)
            6'h00: begin st.push_back(7); rd.push_back(1); st.push_back(8); rd.push_back(0); end
            6'h23: begin
                st.push_back(3); rd.push_back(0);
                for (int i = 0; i < mw; i++) begin st.push_back(4); rd.push_back(0); end
                st.push_back(4); rd.push_back(1);
                st.push_back(5); rd.push_back(0);
            end
            6'h2B: begin
                st.push_back(3); rd.push_back(1);
                for (int i = 0; i < mw; i++) begin st.push_back(6); rd.push_back(0); end
                st.push_back(6); rd.push_back(1);
            end
            6'h04, 6'h05: begin st.push_back(9); rd.push_back(0); end
            6'h08, 6'h0B, 6'h0F, 6'h0D: begin
                st.push_back(10); rd.push_back(0); st.push_back(11); rd.push_back(1);
            end
            6'h02: begin st.push_back(12); rd.push_back(0); end
            default: ;
        endcase
        n = (max_cyc > 0 && max_cyc < st.size()) ? max_cyc : st.size();
        trace = 64'd0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            instr_op_i  = op;
            mem_ready_i = rd[i];
            exp_state   = st[i][3:0];
            exp_rdy     = rd[i];
            chk_en      = 1'b1;
        end
        @(negedge clk_i);
        #1;
        if (max_cyc == 0) begin
            checks++;
            if (trace !== exp_trace || done_cnt != 1) begin
                errors++;
                $display("FAIL %s trace: got %h done=%0d, want %h done=1", name, trace, done_cnt, exp_trace);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        checks++;
        if (got !== '0 || state_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: state %0d outputs %h, want 0 and 0", state_o, got);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || got !== '0) begin
            errors++;
            $display("FAIL idle_after_release: state %0d outputs %h, want 0 and 0", state_o, got);
        end

        run_instr(6'h00, 0, 0, 0, "rtype",      64'h1278);
        run_instr(6'h23, 0, 2, 0, "lw_wait2",   64'h1234445);
        run_instr(6'h05, 0, 0, 0, "bne",        64'h129);
        run_instr(6'h04, 0, 0, 0, "beq",        64'h129);
        run_instr(6'h08, 0, 0, 0, "addi",       64'h12AB);
        run_instr(6'h0B, 0, 0, 0, "sltiu",      64'h12AB);
        run_instr(6'h0F, 0, 0, 0, "lui",        64'h12AB);
        run_instr(6'h0D, 0, 0, 0, "ori",        64'h12AB);
        run_instr(6'h00, 3, 0, 0, "fetch_wait", 64'h1111278);
        run_instr(6'h2B, 0, 0, 0, "sw",         64'h1236);
        run_instr(6'h2B, 0, 2, 0, "sw_wait2",   64'h123666);
        run_instr(6'h23, 0, 0, 0, "lw",         64'h12345);
        run_instr(6'h02, 0, 0, 0, "jump",       64'h12C);
        run_instr(6'h3A, 0, 0, 0, "unknown",    64'h12);

        // Reset while a store is waiting on memory
        run_instr(6'h2B, 0, 3, 4, "sw_abort", 64'h0);
        chk_en = 1'b0;
        checks++;
        if (MemWrite_o !== 1'b1 || state_o !== 4'd6) begin
            errors++;
            $display("FAIL memwr_before_reset: MemWrite %b state %0d, want 1 and 6", MemWrite_o, state_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (got !== '0 || state_o !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: state %0d outputs %h, want 0 and 0", state_o, got);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (got !== '0 || state_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_held_edge: state %0d outputs %h, want 0 and 0", state_o, got);
        end
        rst_i = 1'b1;
        run_instr(6'h3F, 0, 0, 0, "unknown_after_reset", 64'h12);
        run_instr(6'h00, 0, 0, 0, "rtype_final",         64'h1278);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
